// File: rtl/shift_seq_pkg.sv
// Shared types and shifter control codes for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LDC,
    ST_LDD,
    ST_SHIFT,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_RCL = 2'b01,
    OP_ROR = 2'b10,
    OP_RCR = 2'b11
  } op_t;

  // {sh_s, sh_m} codes understood by the attached shifter
  localparam logic [2:0] CODE_HOLD = 3'b000;
  localparam logic [2:0] CODE_ROL  = 3'b010;
  localparam logic [2:0] CODE_RCL  = 3'b011;
  localparam logic [2:0] CODE_ROR  = 3'b100;
  localparam logic [2:0] CODE_RCR  = 3'b101;
  localparam logic [2:0] CODE_LDC  = 3'b110;
  localparam logic [2:0] CODE_LDD  = 3'b111;

  function automatic logic [2:0] shift_code(input op_t op);
    return {op[1], ~op[1], op[0]};
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequences an external shifter: load c0, load data, step count times, capture.
//   state | meaning
//   IDLE  | shifter held, waiting for start
//   LDC   | load shifter c0 from latched cin
//   LDD   | load shifter data from latched operand
//   SHIFT | one rotate step per cycle until the counter reaches 1
//   FIN   | capture shifter data and flags, pulse done
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNTW-1:0]  count,
  input  logic [WIDTH-1:0] operand,
  input  logic             cin,
  output logic [1:0]       sh_s,
  output logic             sh_m,
  output logic [WIDTH-1:0] sh_d,
  input  logic [WIDTH-1:0] sh_q,
  input  logic [15:0]      sh_flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      flag_out
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  state_t           state;
  op_t              op_q;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] operand_q;
  logic             cin_q;
  logic [2:0]       code;

  always_comb begin
    code = CODE_HOLD;
    sh_d = '0;
    case (state)
      ST_LDC: begin
        code = CODE_LDC;
        sh_d = {{(WIDTH-1){1'b0}}, cin_q};
      end
      ST_LDD: begin
        code = CODE_LDD;
        sh_d = operand_q;
      end
      ST_SHIFT: code = shift_code(op_q);
      default:  code = CODE_HOLD;
    endcase
  end

  assign sh_s = code[2:1];
  assign sh_m = code[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_ROL;
      cnt       <= '0;
      operand_q <= '0;
      cin_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      flag_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op_t'(op);
            cnt       <= count;
            operand_q <= operand;
            cin_q     <= cin;
            busy      <= 1'b1;
            state     <= ST_LDC;
          end
        end
        ST_LDC: state <= ST_LDD;
        ST_LDD: state <= (cnt != '0) ? ST_SHIFT : ST_FIN;
        ST_SHIFT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= ST_FIN;
        end
        ST_FIN: begin
          result   <= sh_q;
          flag_out <= sh_flag;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: behavioural shifter, timing/result model, directed commands.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  count = 5'd0;
  logic [15:0] operand = 16'h0;
  logic        cin = 1'b0;
  logic [1:0]  sh_s;
  logic        sh_m;
  logic [15:0] sh_d;
  logic [15:0] sh_q;
  logic [15:0] sh_flag;
  logic        busy, done;
  logic [15:0] result, flag_out;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(16), .CNTW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .count(count),
    .operand(operand), .cin(cin), .sh_s(sh_s), .sh_m(sh_m), .sh_d(sh_d),
    .sh_q(sh_q), .sh_flag(sh_flag), .busy(busy), .done(done),
    .result(result), .flag_out(flag_out)
  );

  // Attached shifter: c0 is only a fill bit, shifts never modify it.
  // Flag bus: bit15 = CN (msb of data), bit1 = c0, bit0 = zero.
  logic [15:0] shq = 16'h0;
  logic        c0 = 1'b0;
  always @(posedge clk) begin
    case ({sh_s, sh_m})
      3'b010: shq <= {shq[14:0], shq[15]};
      3'b011: shq <= {shq[14:0], c0};
      3'b100: shq <= {shq[0], shq[15:1]};
      3'b101: shq <= {c0, shq[15:1]};
      3'b110: c0  <= sh_d[0];
      3'b111: shq <= sh_d;
      default: ;
    endcase
  end
  assign sh_q    = shq;
  assign sh_flag = {shq[15], 13'b0, c0, (shq == 16'h0)};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_res(input logic [1:0] o, input int n,
                                         input logic [15:0] x, input logic c);
    int k;
    logic [15:0] fill;
    k = n % 16;
    case (o)
      2'b00: return (k == 0) ? x : ((x << k) | (x >> (16 - k)));
      2'b10: return (k == 0) ? x : ((x >> k) | (x << (16 - k)));
      2'b01: begin
        if (n >= 16) return {16{c}};
        fill = c ? 16'((32'h1 << n) - 1) : 16'h0;
        return (x << n) | fill;
      end
      default: begin
        if (n >= 16) return {16{c}};
        fill = c ? ~(16'hFFFF >> n) : 16'h0;
        return (x >> n) | fill;
      end
    endcase
  endfunction

  function automatic logic [15:0] exp_flag(input logic [15:0] r, input logic c);
    return {r[15], 13'b0, c, (r == 16'h0)};
  endfunction

  // Model: an accepted command occupies count+3 edges, then done for one cycle.
  int          cyc = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [15:0] m_res = 16'h0, m_flag = 16'h0;
  int          m_e = 0, m_cnt = 0;
  logic [1:0]  m_op = 2'b00;
  logic [15:0] m_x = 16'h0;
  logic        m_c = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = 16'h0; m_flag = 16'h0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_busy) begin
        if (cyc == m_e + m_cnt + 3) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_res  = exp_res(m_op, m_cnt, m_x, m_c);
          m_flag = exp_flag(m_res, m_c);
        end
      end else if (start) begin
        m_busy = 1'b1; m_e = cyc; m_cnt = int'(count);
        m_op = op; m_x = operand; m_c = cin;
      end
    end
  end

  logic [2:0] shift_tbl [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
  always @(negedge clk) begin
    int ph;
    logic [2:0] ec;
    logic [15:0] ed;
    if (!rst) begin
      ec = 3'b000;
      ed = 16'h0;
      if (m_busy) begin
        ph = cyc - m_e;
        if (ph == 0) begin ec = 3'b110; ed = {15'b0, m_c}; end
        else if (ph == 1) begin ec = 3'b111; ed = m_x; end
        else if (ph <= m_cnt + 1) ec = shift_tbl[m_op];
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("sh_code", 32'({sh_s, sh_m}), 32'(ec));
      chk("sh_d", 32'(sh_d), 32'(ed));
      chk("result", 32'(result), 32'(m_res));
      chk("flag_out", 32'(flag_out), 32'(m_flag));
    end
  end

  int e_cyc;

  task automatic issue(input logic [1:0] o, input logic [4:0] c,
                       input logic [15:0] d, input logic ci);
    op = o; count = c; operand = d; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    e_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL done_timeout: got no done, want done within 80 cycles");
    end
    lat = cyc - e_cyc;
  endtask

  initial begin
    int lat, extra;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_code", 32'({sh_s, sh_m}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b00, 5'd4, 16'h8001, 1'b0);
    wait_done(lat);
    chk("rol_lat", 32'(lat), 32'd7);
    chk("rol_res", 32'(result), 32'h0018);
    chk("rol_cn", 32'(flag_out[15]), 32'd0);

    issue(2'b10, 5'd1, 16'h0001, 1'b0);
    wait_done(lat);
    chk("ror_lat", 32'(lat), 32'd4);
    chk("ror_res", 32'(result), 32'h8000);
    chk("ror_cn", 32'(flag_out[15]), 32'd1);

    issue(2'b01, 5'd3, 16'h0000, 1'b1);
    wait_done(lat);
    chk("rcl_res", 32'(result), 32'h0007);

    issue(2'b00, 5'd0, 16'hA5A5, 1'b0);
    wait_done(lat);
    chk("cnt0_lat", 32'(lat), 32'd3);
    chk("cnt0_res", 32'(result), 32'hA5A5);

    issue(2'b00, 5'd20, 16'h1234, 1'b0);
    wait_done(lat);
    chk("rol20_lat", 32'(lat), 32'd23);
    chk("rol20_res", 32'(result), 32'h2341);

    issue(2'b11, 5'd20, 16'h0000, 1'b1);
    wait_done(lat);
    chk("rcr20_res", 32'(result), 32'hFFFF);

    issue(2'b10, 5'd31, 16'h0001, 1'b0);
    wait_done(lat);
    chk("ror31_res", 32'(result), 32'h0002);

    // start while busy is dropped; start in the done cycle is taken
    issue(2'b00, 5'd6, 16'h0003, 1'b0);
    repeat (3) @(negedge clk);
    op = 2'b10; count = 5'd2; operand = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd9);
    chk("ign_res", 32'(result), 32'h00C0);
    issue(2'b10, 5'd2, 16'h0100, 1'b0);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd5);
    chk("b2b_res", 32'(result), 32'h0040);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("no_extra_done", 32'(extra), 32'd0);

    // abort in SHIFT
    issue(2'b00, 5'd10, 16'hFFFF, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flag", 32'(flag_out), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(2'b00, 5'd1, 16'h0001, 1'b0);
    wait_done(lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_res", 32'(result), 32'h0002);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
